// File: rtl/sys_array_pkg.sv
// Shared types for the systolic-array command scheduler: thread states, lock
// encodings and the queued matmul command record.
package sys_array_pkg;

  localparam int ADDR_W = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_REQ  = 3'd1,
    LOADING   = 3'd2,
    LOADED    = 3'd3,
    COMP_REQ  = 3'd4,
    COMPUTING = 3'd5
  } thread_state_t;

  localparam logic [1:0] LOCK_FREE = 2'b00;
  localparam logic [1:0] LOCK_ZERO = 2'b01;
  localparam logic [1:0] LOCK_ONE  = 2'b10;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] d;
    logic [ADDR_W-1:0] c;
    logic [ADDR_W-1:0] b;
  } cmd_t;

  function automatic logic [1:0] lock_mask(input logic thr);
    if (thr) begin
      return LOCK_ONE;
    end else begin
      return LOCK_ZERO;
    end
  endfunction

endpackage

// File: rtl/sys_array_cmd_fifo.sv
// Synchronous command queue; full/empty come from a registered occupancy count
// so cmd_ready never depends on a same-cycle pop.
module sys_array_cmd_fifo
  import sys_array_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  cmd_t wr_data,
  output cmd_t rd_data,
  output logic full,
  output logic empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  cmd_t          mem_q [DEPTH];
  cmd_t          mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push_s, do_pop_s;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign rd_data   = mem_q[rd_ptr_q];

  // Next pointers, occupancy and storage contents.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Queue state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sys_array_cmd_scheduler.sv
// Two-thread matmul command sequencer: overlaps B preload of one command with
// compute of the previous one while keeping compute and completion in issue order.
module sys_array_cmd_scheduler
  import sys_array_pkg::*;
#(
  parameter int ADDRWIDTH = ADDR_W,
  parameter int FIFODEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ADDRWIDTH-1:0]   cmd_a_addr,
  input  logic [ADDRWIDTH-1:0]   cmd_d_addr,
  input  logic [ADDRWIDTH-1:0]   cmd_c_addr,
  input  logic [ADDRWIDTH-1:0]   cmd_b_addr,
  output logic [1:0]             load_lock_req,
  output logic [1:0]             comp_lock_req,
  output logic [2*ADDRWIDTH-1:0] b_addr,
  output logic [2*ADDRWIDTH-1:0] A_addr,
  output logic [2*ADDRWIDTH-1:0] D_addr,
  output logic [2*ADDRWIDTH-1:0] C_addr,
  input  logic [1:0]             load_lock_res,
  input  logic [1:0]             comp_lock_res,
  input  logic                   load_finished,
  input  logic                   comp_finished,
  output logic                   done_valid,
  output logic [ADDRWIDTH-1:0]   done_c_addr,
  output logic                   busy,
  output logic                   proto_err
);

  cmd_t                 fifo_wr_s, fifo_rd_s;
  logic                 fifo_full_s, fifo_empty_s, pop_s;
  logic [1:0]           dispatch_s, idle_s, quiet_s, loading_s, computing_s, done_s;
  logic                 older_ptr_q, older_ptr_d;
  logic                 proto_err_q, proto_err_d;
  logic                 done_valid_q, done_valid_d;
  logic [ADDRWIDTH-1:0] done_c_addr_q, done_c_addr_d;

  assign fifo_wr_s = '{a: cmd_a_addr, d: cmd_d_addr, c: cmd_c_addr, b: cmd_b_addr};

  sys_array_cmd_fifo #(.DEPTH(FIFODEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (cmd_valid),
    .pop     (pop_s),
    .wr_data (fifo_wr_s),
    .rd_data (fifo_rd_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  assign cmd_ready   = !fifo_full_s;
  assign busy        = !fifo_empty_s || !(&idle_s);
  assign pop_s       = |dispatch_s;
  assign done_valid  = done_valid_q;
  assign done_c_addr = done_c_addr_q;
  assign proto_err   = proto_err_q;

  // Head of queue goes to the lowest-numbered idle thread.
  always_comb begin
    dispatch_s = 2'b00;
    if (!fifo_empty_s && idle_s[0]) begin
      dispatch_s = 2'b01;
    end else if (!fifo_empty_s && idle_s[1]) begin
      dispatch_s = 2'b10;
    end else begin
      dispatch_s = 2'b00;
    end
  end

  for (genvar t = 0; t < 2; t++) begin : g_thr
    thread_state_t state_q, state_d;
    cmd_t          ctx_q, ctx_d;
    logic          done_thr_s, load_res_s, comp_res_s;

    assign load_res_s = (load_lock_res & lock_mask(1'(t))) != LOCK_FREE;
    assign comp_res_s = (comp_lock_res & lock_mask(1'(t))) != LOCK_FREE;

    // Per-thread lock handshake; context is cleared on completion so idle addrs read 0.
    always_comb begin
      state_d    = state_q;
      ctx_d      = ctx_q;
      done_thr_s = 1'b0;
      case (state_q)
        IDLE: begin
          if (dispatch_s[t]) begin
            state_d = LOAD_REQ;
            ctx_d   = fifo_rd_s;
          end else begin
            state_d = IDLE;
          end
        end
        LOAD_REQ: begin
          if (load_res_s) state_d = LOADING;
          else            state_d = LOAD_REQ;
        end
        LOADING: begin
          if (load_finished && load_res_s) state_d = LOADED;
          else                             state_d = LOADING;
        end
        LOADED: begin
          if (older_ptr_q == 1'(t)) state_d = COMP_REQ;
          else                      state_d = LOADED;
        end
        COMP_REQ: begin
          if (comp_res_s) state_d = COMPUTING;
          else            state_d = COMP_REQ;
        end
        COMPUTING: begin
          if (comp_finished && comp_res_s) begin
            state_d    = IDLE;
            ctx_d      = '0;
            done_thr_s = 1'b1;
          end else begin
            state_d = COMPUTING;
          end
        end
        default: begin
          state_d = IDLE;
          ctx_d   = '0;
        end
      endcase
    end

    // Thread state and command context registers.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state_q <= IDLE;
        ctx_q   <= '0;
      end else begin
        state_q <= state_d;
        ctx_q   <= ctx_d;
      end
    end

    assign idle_s[t]        = (state_q == IDLE);
    assign quiet_s[t]       = (state_q == IDLE) || (state_q == LOADED);
    assign loading_s[t]     = (state_q == LOADING);
    assign computing_s[t]   = (state_q == COMPUTING);
    assign done_s[t]        = done_thr_s;
    assign load_lock_req[t] = (state_q == LOAD_REQ) || (state_q == LOADING);
    assign comp_lock_req[t] = (state_q == COMP_REQ) || (state_q == COMPUTING);
    assign A_addr[t*ADDRWIDTH +: ADDRWIDTH] = ctx_q.a;
    assign D_addr[t*ADDRWIDTH +: ADDRWIDTH] = ctx_q.d;
    assign C_addr[t*ADDRWIDTH +: ADDRWIDTH] = ctx_q.c;
    assign b_addr[t*ADDRWIDTH +: ADDRWIDTH] = ctx_q.b;
  end

  // A thread dispatched while its sibling is idle becomes the oldest; completion hands over.
  always_comb begin
    older_ptr_d = older_ptr_q;
    if (done_s[0]) begin
      older_ptr_d = 1'b1;
    end else if (done_s[1]) begin
      older_ptr_d = 1'b0;
    end else if (dispatch_s[0] && idle_s[1]) begin
      older_ptr_d = 1'b0;
    end else begin
      older_ptr_d = older_ptr_q;
    end
  end

  // Completion report for the thread that just finished compute.
  always_comb begin
    done_valid_d  = |done_s;
    done_c_addr_d = '0;
    if (done_s[0]) begin
      done_c_addr_d = C_addr[ADDRWIDTH-1:0];
    end else if (done_s[1]) begin
      done_c_addr_d = C_addr[2*ADDRWIDTH-1:ADDRWIDTH];
    end else begin
      done_c_addr_d = '0;
    end
  end

  // Sticky flag for grants or finish pulses the threads never asked for.
  always_comb begin
    proto_err_d = proto_err_q;
    if (|((load_lock_res | comp_lock_res) & quiet_s)) begin
      proto_err_d = 1'b1;
    end else if (load_finished && ~|(loading_s & load_lock_res)) begin
      proto_err_d = 1'b1;
    end else if (comp_finished && ~|(computing_s & comp_lock_res)) begin
      proto_err_d = 1'b1;
    end else begin
      proto_err_d = proto_err_q;
    end
  end

  // Top-level ordering, status and report registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      older_ptr_q   <= 1'b0;
      proto_err_q   <= 1'b0;
      done_valid_q  <= 1'b0;
      done_c_addr_q <= '0;
    end else begin
      older_ptr_q   <= older_ptr_d;
      proto_err_q   <= proto_err_d;
      done_valid_q  <= done_valid_d;
      done_c_addr_q <= done_c_addr_d;
    end
  end

endmodule
